// File: rtl/reg_file_port_ctrl.sv
// rtl/reg_file_port_ctrl.sv - byte-stream load/dump controller for an 8x8 register file
//
// Moves the whole register file in or out over byte streams.
//   LOAD : accepts 8 bytes on IN_DATA/IN_VALID/IN_READY and writes them to
//          registers 0..7 through WRITEDATA/WRITEREG/WRITEENABLE.
//   DUMP : reads registers 0..7 through READREG1/REGOUT1 and presents them on
//          OUT_DATA/OUT_VALID/OUT_READY.
// Ports:
//   CLK, RESET                   clock, asynchronous active-high reset
//   LOAD_START, DUMP_START       operation requests, sampled in IDLE only
//   IN_DATA, IN_VALID, IN_READY  load byte stream
//   OUT_DATA, OUT_VALID, OUT_READY  dump byte stream
//   WRITEDATA, WRITEREG, WRITEENABLE  register file write port
//   READREG1, REGOUT1            register file combinational read port
//   BUSY                         high outside IDLE
//   DONE                         one-cycle completion pulse

module reg_file_port_ctrl (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       LOAD_START,
    input  logic       DUMP_START,
    input  logic [7:0] IN_DATA,
    input  logic       IN_VALID,
    output logic       IN_READY,
    output logic [7:0] OUT_DATA,
    output logic       OUT_VALID,
    input  logic       OUT_READY,
    output logic [7:0] WRITEDATA,
    output logic [2:0] WRITEREG,
    output logic       WRITEENABLE,
    output logic [2:0] READREG1,
    input  logic [7:0] REGOUT1,
    output logic       BUSY,
    output logic       DONE
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LOAD      = 3'd1;
    localparam logic [2:0] DUMP_ADDR = 3'd2;
    localparam logic [2:0] DUMP_OUT  = 3'd3;
    localparam logic [2:0] FINISH    = 3'd4;

    logic [2:0] state;
    logic [2:0] idx;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= IDLE;
            idx         <= 3'd0;
            OUT_DATA    <= 8'd0;
            OUT_VALID   <= 1'b0;
            WRITEDATA   <= 8'd0;
            WRITEREG    <= 3'd0;
            WRITEENABLE <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse per accepted byte; the
            // final byte's pulse lands in FINISH.
            WRITEENABLE <= 1'b0;
            case (state)
                IDLE: begin
                    if (LOAD_START) begin
                        state <= LOAD;
                        idx   <= 3'd0;
                    end else if (DUMP_START) begin
                        state <= DUMP_ADDR;
                        idx   <= 3'd0;
                    end
                end
                LOAD: begin
                    if (IN_VALID) begin
                        WRITEDATA   <= IN_DATA;
                        WRITEREG    <= idx;
                        WRITEENABLE <= 1'b1;
                        // Hold idx at 7 on the last byte so it never wraps
                        // inside an operation.
                        if (idx == 3'd7) begin
                            state <= FINISH;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                DUMP_ADDR: begin
                    // READREG1 has been stable for this whole cycle, so the
                    // register file output is settled at this edge.
                    OUT_DATA  <= REGOUT1;
                    OUT_VALID <= 1'b1;
                    state     <= DUMP_OUT;
                end
                DUMP_OUT: begin
                    if (OUT_READY) begin
                        OUT_VALID <= 1'b0;
                        if (idx == 3'd7) begin
                            state <= FINISH;
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= DUMP_ADDR;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign IN_READY = (state == LOAD);
    assign BUSY     = (state != IDLE);
    assign DONE     = (state == FINISH);
    assign READREG1 = ((state == DUMP_ADDR) || (state == DUMP_OUT)) ? idx : 3'd0;

endmodule

// File: doc/reg_file_port_ctrl.md
REG_FILE_PORT_CTRL -- requirements
Module: reg_file_port_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high; ports named CLK and RESET.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RESET  input  1  asynchronous active-high reset.
REQ-004 LOAD_START  input  1  request to load all 8 registers from the input byte stream; sampled in IDLE only.
REQ-005 DUMP_START  input  1  request to read all 8 registers out to the output byte stream; sampled in IDLE only.
REQ-006 IN_DATA  input  8  load byte.
REQ-007 IN_VALID  input  1  IN_DATA valid.
REQ-008 IN_READY  output  1  block accepts IN_DATA.
REQ-009 OUT_DATA  output  8  dumped register value.
REQ-010 OUT_VALID  output  1  OUT_DATA valid.
REQ-011 OUT_READY  input  1  consumer accepts OUT_DATA.
REQ-012 WRITEDATA  output  8  register file write data.
REQ-013 WRITEREG  output  3  register file write address.
REQ-014 WRITEENABLE  output  1  register file write enable; register file writes on the rising edge where it is high.
REQ-015 READREG1  output  3  register file read address (combinational read port).
REQ-016 REGOUT1  input  8  register file read data for READREG1.
REQ-017 BUSY  output  1  high whenever state is not IDLE.
REQ-018 DONE  output  1  one-cycle pulse on completion of a load or dump.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, DUMP_ADDR, DUMP_OUT, FINISH; one 3-bit index counter IDX shared by load and dump.
REQ-020 IDLE: LOAD_START=1 -> LOAD with IDX=0; else DUMP_START=1 -> DUMP_ADDR with IDX=0; both high -> LOAD wins.
REQ-021 LOAD_START/DUMP_START outside IDLE SHALL be ignored (no queuing).
REQ-022 LOAD: IN_READY=1; handshake = IN_VALID & IN_READY at a rising edge.
REQ-023 On each LOAD handshake, at that edge the block SHALL register WRITEDATA<=IN_DATA, WRITEREG<=IDX, WRITEENABLE<=1, so the write commits at the following edge; IDX increments.
REQ-024 WRITEENABLE SHALL be high for exactly one cycle per accepted byte; cycles with no handshake drive WRITEENABLE=0.
REQ-025 Back-to-back handshakes SHALL be accepted every cycle (throughput 1 byte/cycle).
REQ-026 Handshake with IDX=7 -> FINISH; IN_READY=0 in every state other than LOAD.
REQ-027 DUMP_ADDR: READREG1=IDX for one full cycle (covers register file read delay); at its end edge OUT_DATA<=REGOUT1, OUT_VALID<=1, state -> DUMP_OUT.
REQ-028 DUMP_OUT: OUT_VALID=1; OUT_DATA and READREG1 held stable until OUT_READY=1 at an edge.
REQ-029 DUMP_OUT handshake: OUT_VALID<=0; IDX=7 -> FINISH, else IDX+1 -> DUMP_ADDR (2 cycles/byte minimum).
REQ-030 FINISH: DONE=1 for exactly this cycle; WRITEENABLE may be high here only for the final load byte; next state IDLE.
REQ-031 Load latency: LOAD_START at edge E0, 8 consecutive handshakes at E1..E8 -> DONE high E8..E9, register 7 written at E9, BUSY low after E9.
REQ-032 IDX wrap 7->0 SHALL NOT occur within an operation; IDX resets to 0 on every start.
REQ-033 IN_VALID during DUMP or IDLE SHALL have no effect; OUT_READY without OUT_VALID SHALL have no effect.

Reset
REQ-034 RESET=1 SHALL immediately (asynchronously) force state IDLE, IDX=0, and all outputs 0: IN_READY, OUT_VALID, OUT_DATA, WRITEDATA, WRITEREG, WRITEENABLE, READREG1, BUSY, DONE.
REQ-035 Reset mid-operation SHALL abort it with no further write and no DONE; a write pending at reset SHALL be dropped.
REQ-036 After RESET falls the block SHALL accept a start on the first rising edge.

Verification
REQ-037 Load 8'd10..8'd17 back-to-back then dump with OUT_READY=1 -> OUT_DATA sequence 10..17, DONE once per operation, regs 0..7 = 10..17.
REQ-038 Load with IN_VALID toggling every other cycle -> exactly 8 one-cycle WRITEENABLE pulses, WRITEREG 0..7 in order, no duplicates.
REQ-039 Dump with OUT_READY held 0 for 5 cycles on byte 3 -> OUT_VALID stays 1, OUT_DATA stable at reg3 value, then continues with reg4.
REQ-040 LOAD_START and DUMP_START high together in IDLE -> LOAD entered, IN_READY=1; DUMP_START pulses during load ignored.
REQ-041 RESET asserted after 4th load handshake -> WRITEENABLE=0 same instant, regs 4..7 unchanged, BUSY=0, DONE never pulses.
REQ-042 Write 8'd56 via load to reg3, dump -> reg3 byte is 56; OUT_DATA sampled from REGOUT1 one full cycle after READREG1 changes.
